// File: rtl/nova_mm_arb_if.sv
// Bus bundle for nova_mm_arb: CPU and data-channel request ports plus the RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface nova_mm_arb_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [0:15] cpu_adr;
  logic [0:15] cpu_din;
  logic        cpu_ack;
  logic [0:15] cpu_rdata;
  logic        dch_req;
  logic        dch_we;
  logic [0:15] dch_adr;
  logic [0:15] dch_din;
  logic        dch_ack;
  logic [0:15] dch_rdata;
  logic [0:15] mm_adr;
  logic        mm_we;
  logic [0:15] mm_din;
  logic [0:15] mm_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_din,
    input  dch_req, dch_we, dch_adr, dch_din,
    input  mm_dout,
    output cpu_ack, cpu_rdata, dch_ack, dch_rdata,
    output mm_adr, mm_we, mm_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_din,
    output dch_req, dch_we, dch_adr, dch_din,
    output mm_dout,
    input  cpu_ack, cpu_rdata, dch_ack, dch_rdata,
    input  mm_adr, mm_we, mm_din
  );
endinterface

// File: rtl/nova_mm_arb.sv
// Two-requester (CPU, data channel) arbiter for the main RAM port, IDLE->GNT->ACK per access.
// Define NOVA_MM_ARB_FAIR_EN to cap consecutive DCH grants at DCH_BURST while the CPU waits.
module nova_mm_arb #(
  parameter int DCH_BURST = 4
) (
  input logic          pclk,
  input logic          prst_n,
  nova_mm_arb_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  if ((DCH_BURST < 1) || (DCH_BURST > 15)) begin : g_bad_burst
    $error("nova_mm_arb: DCH_BURST must be 1..15");
  end

  logic [1:0]  state_r;
  logic        dch_sel_r;
  logic [0:15] mm_adr_r;
  logic [0:15] mm_din_r;
  logic        mm_we_r;
  logic        cpu_ack_r;
  logic        dch_ack_r;
  logic [0:15] cpu_rdata_r;
  logic [0:15] dch_rdata_r;

  logic        any_req_s;
  logic        pick_dch_s;
  logic        sel_we_s;
  logic [0:15] sel_adr_s;
  logic [0:15] sel_din_s;

`ifdef NOVA_MM_ARB_FAIR_EN
  localparam logic [3:0] BURST_LIM = 4'(DCH_BURST);
  logic [3:0] fair_cnt_r;
`endif

  // Winner selection and request mux for the IDLE sample
  always_comb begin
    any_req_s  = bus.cpu_req | bus.dch_req;
    pick_dch_s = 1'b0;
    if (bus.dch_req) begin
`ifdef NOVA_MM_ARB_FAIR_EN
      if (bus.cpu_req && (fair_cnt_r == BURST_LIM)) begin
        pick_dch_s = 1'b0;
      end else begin
        pick_dch_s = 1'b1;
      end
`else
      pick_dch_s = 1'b1;
`endif
    end else begin
      pick_dch_s = 1'b0;
    end
    if (pick_dch_s) begin
      sel_we_s  = bus.dch_we;
      sel_adr_s = bus.dch_adr;
      sel_din_s = bus.dch_din;
    end else begin
      sel_we_s  = bus.cpu_we;
      sel_adr_s = bus.cpu_adr;
      sel_din_s = bus.cpu_din;
    end
  end

  // Access sequencer; the RAM port registers double as the latched request
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_r     <= ST_IDLE;
      dch_sel_r   <= 1'b0;
      mm_adr_r    <= 16'h0000;
      mm_din_r    <= 16'h0000;
      mm_we_r     <= 1'b0;
      cpu_ack_r   <= 1'b0;
      dch_ack_r   <= 1'b0;
      cpu_rdata_r <= 16'h0000;
      dch_rdata_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r   <= ST_GNT;
            dch_sel_r <= pick_dch_s;
            mm_adr_r  <= sel_adr_s;
            mm_din_r  <= sel_din_s;
            mm_we_r   <= sel_we_s;
          end
        end
        ST_GNT: begin
          if (!mm_we_r) begin
            if (dch_sel_r) begin
              dch_rdata_r <= bus.mm_dout;
            end else begin
              cpu_rdata_r <= bus.mm_dout;
            end
          end
          cpu_ack_r <= ~dch_sel_r;
          dch_ack_r <= dch_sel_r;
          mm_adr_r  <= 16'h0000;
          mm_din_r  <= 16'h0000;
          mm_we_r   <= 1'b0;
          state_r   <= ST_ACK;
        end
        ST_ACK: begin
          cpu_ack_r <= 1'b0;
          dch_ack_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          cpu_ack_r <= 1'b0;
          dch_ack_r <= 1'b0;
          mm_adr_r  <= 16'h0000;
          mm_din_r  <= 16'h0000;
          mm_we_r   <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NOVA_MM_ARB_FAIR_EN
  // Consecutive-DCH-grant counter; only meaningful while the CPU is waiting
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      fair_cnt_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      if (!bus.cpu_req) begin
        fair_cnt_r <= 4'd0;
      end else if (pick_dch_s) begin
        fair_cnt_r <= fair_cnt_r + 4'd1;
      end else begin
        fair_cnt_r <= 4'd0;
      end
    end else begin
      fair_cnt_r <= fair_cnt_r;
    end
  end
`endif

  assign bus.mm_adr    = mm_adr_r;
  assign bus.mm_din    = mm_din_r;
  assign bus.mm_we     = mm_we_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dch_ack   = dch_ack_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dch_rdata = dch_rdata_r;

endmodule

// File: doc/nova_mm_arb.md
# nova_mm_arb

Memory-bus arbiter sitting directly upstream of the main RAM. It multiplexes two requesters onto the single RAM port (`mm_adr`/`mm_we`/`mm_din`/`mm_dout`): the CPU and the data channel (DCH, device DMA). Each access is a registered req/ack transaction. The data channel has priority, with an optional fairness limit on consecutive DCH grants. Read data is captured from the RAM's combinational output and returned with the ack.

## Interface
- `DCH_BURST`, default 4: maximum consecutive DCH grants while the CPU is waiting (fairness build only); legal range 1..15.
- `pclk`  in  1  system clock, all state on rising edge.
- `prst_n`  in  1  reset; asynchronous, active-low.
- `cpu_req`  in  1  CPU access request; held until ack.
- `cpu_we`  in  1  1 = write, 0 = read; stable while req.
- `cpu_adr`  in  [0:15]  word address.
- `cpu_din`  in  [0:15]  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  [0:15]  read data; valid with ack, held until the next CPU read ack.
- `dch_req`, `dch_we`, `dch_adr`, `dch_din`, `dch_ack`, `dch_rdata`: same as the CPU set, for the data channel.
- `mm_adr`  out  [0:15]  RAM address.
- `mm_we`  out  1  RAM write strobe.
- `mm_din`  out  [0:15]  RAM write data.
- `mm_dout`  in  [0:15]  RAM read data; combinational, valid when `mm_we`=0.

## Operation
- FSM states:
  - IDLE: sample requests at the edge.
    - Any req: latch the winner's adr/we/din and go to GNT.
    - No req: stay in IDLE.
  - GNT: the RAM port is driven from the latched request.
    - If read, capture `mm_dout` into the winner's rdata register at the edge.
    - Always go to ACK.
  - ACK: pulse the winner's ack, then go to IDLE.
  - No request is sampled in ACK.
- Arbitration: with both reqs high in IDLE, DCH wins, unless the fairness limit is hit (see Configuration).
- Requester rule: req, we, adr and din stay stable from assertion until the edge at which ack=1 is seen.
  - The requester then drops req at that edge, or holds it to request a new access.
- RAM port outside GNT: `mm_adr`=0, `mm_din`=0, `mm_we`=0.
  - `mm_we`=1 only in GNT of a write.
- Writes return ack with rdata unchanged.
- Only one ack is high in any cycle; acks are never high outside ACK.
- A req deasserted before grant is ignored without error. No abort mid-access.
- Reset (async, any state):
  - FSM goes to IDLE.
  - Acks, `mm_we`, `mm_adr` and `mm_din` go to 0.
  - Both rdata registers go to 0, and the fairness counter goes to 0.
  - A write in GNT when reset asserts is abandoned. No write strobe is issued after reset.

## Timing
- Edge N samples req in IDLE; cycle N+1 is GNT (RAM driven); cycle N+2 is ACK (ack=1, rdata valid).
- Latency: 2 cycles from sampling edge to ack.
- Throughput: one access per 3 cycles under continuous requests.
- Write commit: RAM writes at the edge ending GNT.
- Read: `mm_dout` is sampled at the edge ending GNT.
- Back-to-back from one port: ack seen at edge M, req still high; IDLE samples at edge M+1; next ack at cycle M+3.
- Both ports requesting continuously in the strict build: CPU never granted (documented starvation).

## Configuration
- `NOVA_MM_ARB_FAIR_EN` defined:
  - A 4-bit counter increments on each DCH grant made while `cpu_req`=1.
  - It clears on any CPU grant, and on any IDLE sample with `cpu_req`=0.
  - When counter = `DCH_BURST` and both reqs are high, the CPU wins.
- Undefined: strict DCH priority; no counter logic; `DCH_BURST` ignored.

## Test plan
- Reset, then CPU write adr 0x0010 data 0x1234 → `mm_we`=1 for exactly one cycle with `mm_adr`=0x0010 and `mm_din`=0x1234; `cpu_ack` pulses 2 cycles after the sampling edge.
- CPU read 0x0010 → `cpu_rdata`=0x1234 in the ack cycle and held afterwards; `dch_ack` stays 0 throughout.
- Both reqs asserted in the same cycle (DCH write 0x0020←0xBEEF, CPU read 0x0020) → DCH is granted first; the CPU read then returns 0xBEEF.
- Continuous DCH and CPU requests, fairness build with DCH_BURST=4 → grant pattern DCH×4, CPU, DCH×4, CPU…. Strict build → DCH only, zero CPU acks in 30 cycles.
- `prst_n` asserted low mid-GNT of a write → `mm_we`, acks and rdata are 0 immediately (before the next clock edge); FSM is in IDLE after release; no ack for the aborted request until it is re-requested.
- Back-to-back DCH reads of 0x0000..0x0003 with req held → acks every 3 cycles, each with the correct data, and no duplicate grants.
